// File: rtl/rb_unpack.sv
// Burst read-back from the shared result RAM: reads four consecutive words starting at
// an auto-incrementing pointer and presents their low DATA_W bits in parallel as MU1..MU4.
module rb_unpack #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 18,
    parameter int WORDS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_addr,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              re_n,
    output logic [7:0]        r_addr,
    input  logic [31:0]       dataRAM_in,
    output logic [DATA_W-1:0] MU1,
    output logic [DATA_W-1:0] MU2,
    output logic [DATA_W-1:0] MU3,
    output logic [DATA_W-1:0] MU4,
    output logic              valid,
    output logic              busy
);

    localparam int CNT_W = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, READ, LAST} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   ptr_reg, ptr_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [DATA_W-1:0]   buf_reg [0:WORDS-2];
    logic [DATA_W-1:0]   mu_reg  [0:WORDS-1];
    logic                valid_reg;
    logic [DATA_W-1:0]   word;
    logic                unused_hi;

    assign word      = dataRAM_in[DATA_W-1:0];
    assign unused_hi = ^dataRAM_in[31:DATA_W];

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                // A load in the same cycle as start sets the burst's first address.
                if (ld_addr)
                    ptr_next = addr_in;
                if (start) begin
                    state_next = READ;
                    cnt_next   = '0;
                end
            end
            READ: begin
                ptr_next = ptr_reg + 1'b1;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(WORDS - 1))
                    state_next = LAST;
            end
            LAST: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            valid_reg <= (state_reg == LAST);
        end
    end

    // Read data lags re_n by one cycle, so word k lands while cnt_reg == k+1.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS - 1; gi++) begin : g_buf
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    buf_reg[gi] <= '0;
                else if (state_reg == READ && cnt_reg == CNT_W'(gi + 1))
                    buf_reg[gi] <= word;
            end
        end

        for (gi = 0; gi < WORDS; gi++) begin : g_mu
            if (gi == WORDS - 1) begin : g_direct
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst)
                        mu_reg[gi] <= '0;
                    else if (state_reg == LAST)
                        mu_reg[gi] <= word;
                end
            end else begin : g_buffered
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst)
                        mu_reg[gi] <= '0;
                    else if (state_reg == LAST)
                        mu_reg[gi] <= buf_reg[gi];
                end
            end
        end
    endgenerate

    assign re_n   = (state_reg != READ);
    assign r_addr = {{(8 - ADDR_W){1'b0}}, ptr_reg};
    assign busy   = (state_reg != IDLE);
    assign valid  = valid_reg;
    assign MU1    = mu_reg[0];
    assign MU2    = mu_reg[1];
    assign MU3    = mu_reg[2];
    assign MU4    = mu_reg[3];

endmodule
